// File: rtl/am4_useq_pkg.sv
// Shared definitions for the M4 microprogram sequencer and its mcrom instantiation.
package am4_useq_pkg;

    localparam int unsigned AW = 10;
    localparam int unsigned SD = 4;

    typedef enum logic [1:0] {
        SEL_UPC = 2'd0,
        SEL_R   = 2'd1,
        SEL_STK = 2'd2,
        SEL_D   = 2'd3
    } sel_e;

    // Encoding 3 is deliberately absent: it behaves as hold.
    typedef enum logic [1:0] {
        STK_HOLD = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2
    } stk_op_e;

endpackage

// File: rtl/am4_useq_stack.sv
// Subroutine return stack: circular register file, pointer, depth count and sticky flags.
module am4_useq_stack #(
    parameter int unsigned AW = 10,
    parameter int unsigned SD = 4,
    localparam int unsigned PW = $clog2(SD),
    localparam int unsigned DW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] wdata,
    output logic [AW-1:0] top,
    output logic [PW-1:0] sp,
    output logic [DW-1:0] depth,
    output logic          ovf,
    output logic          udf
);

    logic [AW-1:0] stk [SD];
    logic [PW-1:0] sp_q, sp_inc;
    logic [DW-1:0] depth_q;
    logic          ovf_q, udf_q;
    logic          full, empty;

    assign sp_inc = sp_q + PW'(1);
    assign full   = (depth_q == DW'(SD));
    assign empty  = (depth_q == '0);

    // Pointer, depth and flags; pointer wraps freely even on over/underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (push) begin
            sp_q <= sp_inc;
            if (full) ovf_q   <= 1'b1;
            else      depth_q <= depth_q + DW'(1);
        end else if (pop) begin
            sp_q <= sp_q - PW'(1);
            if (empty) udf_q   <= 1'b1;
            else       depth_q <= depth_q - DW'(1);
        end
    end

    // Single write port above the current top; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) stk[sp_inc] <= wdata;
    end

    assign top   = stk[sp_q];
    assign sp    = sp_q;
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: rtl/am4_useq.sv
// Microprogram sequencer: source mux, zero/OR-mask modifiers, uPC, R register and return stack.
module am4_useq #(
    parameter int unsigned AW = am4_useq_pkg::AW,
    parameter int unsigned SD = am4_useq_pkg::SD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [AW-1:0]         d,
    input  logic                  r_ld,
    input  logic [1:0]            sel,
    input  logic [1:0]            stk_op,
    input  logic                  zero,
    input  logic [3:0]            orm,
    input  logic                  cin,
    output logic [AW-1:0]         addr,
    output logic [$clog2(SD)-1:0] sp,
    output logic [$clog2(SD):0]   depth,
    output logic                  ovf,
    output logic                  udf
);

    import am4_useq_pkg::*;

    logic [AW-1:0] upc_q, upc_d, r_q;
    logic [AW-1:0] src, stk_top;
    logic          push, pop;

    assign push = ena && (stk_op == STK_PUSH);
    assign pop  = ena && (stk_op == STK_POP);

    // Address source select.
    always_comb begin
        src = upc_q;
        case (sel)
            SEL_UPC: src = upc_q;
            SEL_R:   src = r_q;
            SEL_STK: src = stk_top;
            SEL_D:   src = d;
            default: src = upc_q;
        endcase
    end

    // Branch modifiers; zero (and reset) dominate the OR-mask.
    always_comb begin
        addr = src | {{(AW-4){1'b0}}, orm};
        if (zero || rst) addr = '0;
    end

    assign upc_d = addr + {{(AW-1){1'b0}}, cin};

    // uPC follows the issued address; R loads only on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q <= '0;
            r_q   <= '0;
        end else if (ena) begin
            upc_q <= upc_d;
            if (r_ld) r_q <= d;
        end
    end

    // Push saves the pre-edge uPC, i.e. the return address.
    am4_useq_stack #(
        .AW (AW),
        .SD (SD)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (upc_q),
        .top   (stk_top),
        .sp    (sp),
        .depth (depth),
        .ovf   (ovf),
        .udf   (udf)
    );

endmodule

// File: tb/tb_am4_useq.sv
// Directed bench for am4_useq with a cycle-level behavioural model and literal pins.
module tb_am4_useq;
    import am4_useq_pkg::*;

    logic       clk = 1'b0, rst = 1'b0, ena = 1'b0, r_ld = 1'b0, zero = 1'b0, cin = 1'b0;
    logic [9:0] d = '0;
    logic [1:0] sel = '0, stk_op = '0;
    logic [3:0] orm = '0;
    logic [9:0] addr;
    logic [1:0] sp;
    logic [2:0] depth;
    logic       ovf, udf;

    int n_vec = 0, n_err = 0;
    bit run = 1'b0;

    // Behavioural model state (integers, ring of four return slots).
    int m_upc = 0, m_r = 0, m_sp = 0, m_depth = 0;
    bit m_ovf = 1'b0, m_udf = 1'b0;
    int m_stk [4];
    bit m_vld [4];

    am4_useq dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .d      (d),
        .r_ld   (r_ld),
        .sel    (sel),
        .stk_op (stk_op),
        .zero   (zero),
        .orm    (orm),
        .cin    (cin),
        .addr   (addr),
        .sp     (sp),
        .depth  (depth),
        .ovf    (ovf),
        .udf    (udf)
    );

    always #5 clk = ~clk;

    function automatic int m_addr();
        int s;
        case (int'(sel))
            0:       s = m_upc;
            1:       s = m_r;
            2:       s = m_stk[m_sp];
            default: s = int'(d);
        endcase
        if (zero || rst) return 0;
        return s | int'(orm);
    endfunction

    function automatic bit m_addr_known();
        return !(int'(sel) == 2 && !zero && !rst && !m_vld[m_sp]);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_upc   <= 0;
            m_r     <= 0;
            m_sp    <= 0;
            m_depth <= 0;
            m_ovf   <= 1'b0;
            m_udf   <= 1'b0;
            for (int i = 0; i < 4; i++) m_vld[i] <= 1'b0;
        end else if (ena) begin
            m_upc <= (m_addr() + int'(cin)) % 1024;
            if (r_ld) m_r <= int'(d);
            if (int'(stk_op) == 1) begin
                m_stk[(m_sp + 1) % 4] <= m_upc;
                m_vld[(m_sp + 1) % 4] <= 1'b1;
                m_sp <= (m_sp + 1) % 4;
                if (m_depth == 4) m_ovf <= 1'b1;
                else              m_depth <= m_depth + 1;
            end else if (int'(stk_op) == 2) begin
                m_sp <= (m_sp + 3) % 4;
                if (m_depth == 0) m_udf <= 1'b1;
                else              m_depth <= m_depth - 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            if (m_addr_known()) chk("addr", int'(addr), m_addr());
            chk("sp", int'(sp), m_sp);
            chk("depth", int'(depth), m_depth);
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("udf", int'(udf), int'(m_udf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [9:0] dd, input logic [1:0] op,
                         input logic c);
        sel    = s;
        d      = dd;
        stk_op = op;
        cin    = c;
        ena    = 1'b1;
        r_ld   = 1'b0;
        zero   = 1'b0;
        orm    = 4'h0;
    endtask

    initial begin
        // Reset and sequential run.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run = 1'b1;
        drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        #1 chk("run_addr0", int'(addr), 0);
        chk("run_depth", int'(depth), 0);
        chk("run_flags", int'({ovf, udf}), 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1 chk("run_addr", int'(addr), i);
        end

        // Call / return.
        tick(); drive(SEL_D, 10'h00F, STK_HOLD, 1'b1);
        tick(); drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        #1 chk("call_site", int'(addr), 'h010);
        tick(); drive(SEL_D, 10'h200, STK_PUSH, 1'b1);
        #1 chk("call_addr", int'(addr), 'h200);
        tick(); drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        #1 chk("call_depth", int'(depth), 1);
        chk("sub_addr", int'(addr), 'h201);
        tick(); drive(SEL_STK, 10'h000, STK_POP, 1'b1);
        #1 chk("ret_addr", int'(addr), 'h011);
        tick(); drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        #1 chk("ret_depth", int'(depth), 0);
        chk("ret_next", int'(addr), 'h012);

        // Multiway branch.
        tick(); drive(SEL_UPC, 10'h120, STK_HOLD, 1'b1);
        r_ld = 1'b1;
        tick(); drive(SEL_R, 10'h000, STK_HOLD, 1'b1);
        orm = 4'hA;
        #1 chk("orm_addr", int'(addr), 'h12A);
        zero = 1'b1;
        #1 chk("zero_addr", int'(addr), 0);

        // Overflow then unwind.
        tick(); drive(SEL_D, 10'h100, STK_HOLD, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(); drive(SEL_UPC, 10'h000, STK_PUSH, 1'b1);
            #1 chk("push_addr", int'(addr), 'h101 + k);
        end
        tick(); drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        #1 chk("ovf_depth", int'(depth), 4);
        chk("ovf_flag", int'(ovf), 1);
        for (int k = 0; k < 4; k++) begin
            tick(); drive(SEL_STK, 10'h000, STK_POP, 1'b1);
            #1 chk("pop_addr", int'(addr), 'h105 - k);
        end
        tick(); drive(SEL_UPC, 10'h000, STK_POP, 1'b1);
        tick(); drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        #1 chk("udf_flag", int'(udf), 1);
        chk("udf_depth", int'(depth), 0);

        // Enable stall at the top of the address space, then wrap.
        tick(); drive(SEL_D, 10'h3FE, STK_HOLD, 1'b1);
        tick(); drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        ena = 1'b0;
        #1 chk("stall_addr", int'(addr), 'h3FF);
        for (int k = 0; k < 2; k++) begin
            tick();
            #1 chk("stall_addr", int'(addr), 'h3FF);
        end
        tick(); ena = 1'b1;
        #1 chk("stall_release", int'(addr), 'h3FF);
        tick();
        #1 chk("wrap_addr", int'(addr), 0);

        // Asynchronous reset between edges.
        tick(); drive(SEL_D, 10'h152, STK_PUSH, 1'b1);
        tick(); drive(SEL_UPC, 10'h000, STK_PUSH, 1'b1);
        #1 chk("pre_rst_addr", int'(addr), 'h153);
        tick(); drive(SEL_UPC, 10'h000, STK_HOLD, 1'b1);
        tick();
        #1 chk("pre_rst_upc", int'(addr), 'h155);
        chk("pre_rst_depth", int'(depth), 2);
        #1 rst = 1'b1;
        #1 chk("arst_addr", int'(addr), 0);
        chk("arst_upc", int'(dut.upc_q), 0);
        chk("arst_sp", int'(sp), 0);
        chk("arst_depth", int'(depth), 0);
        chk("arst_flags", int'({ovf, udf}), 0);
        tick(); tick();
        rst = 1'b0;
        #1 chk("post_rst_addr", int'(addr), 0);
        tick();
        #1 chk("post_rst_next", int'(addr), 1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
